// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port data RAM: one access in flight at a time,
// with round-robin or fixed priority, a bounded wait for ram_valid and routed completions.
module ram_arbiter #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 16,
    parameter int TIMEOUT    = 15,
    parameter int TW         = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_wen,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic              m0_valid,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_wen,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic              m1_valid,
    output logic              m1_err,
    output logic              ram_en,
    output logic              ram_wen,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata,
    input  logic              ram_valid,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              last_grant;
    logic              grant;
    logic [TW-1:0]     count;
    logic              pick_m1;
    logic              done;
    logic              timed_out;
    logic [DWIDTH-1:0] done_rdata;

    // On a tie, round-robin hands the grant to whichever master did not win last time.
    always_comb begin
        pick_m1 = 1'b0;
        if (m0_req && m1_req)
            pick_m1 = (FIXED_PRIO == 0) && !last_grant;
        else
            pick_m1 = m1_req;
    end

    // ram_valid wins over the timeout when both land on the final wait cycle.
    always_comb begin
        done      = 1'b0;
        timed_out = 1'b0;
        if (state == ISSUE) begin
            done = ram_valid;
        end else if (state == WAIT) begin
            done      = ram_valid || (count == TW'(TIMEOUT - 1));
            timed_out = !ram_valid;
        end
        done_rdata = (ram_valid && !ram_wen) ? ram_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            count      <= '0;
            m0_rdata   <= '0;
            m0_valid   <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= '0;
            m1_valid   <= 1'b0;
            m1_err     <= 1'b0;
            ram_en     <= 1'b0;
            ram_wen    <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant      <= pick_m1;
                        last_grant <= pick_m1;
                        ram_en     <= 1'b1;
                        ram_wen    <= pick_m1 ? m1_wen   : m0_wen;
                        ram_addr   <= pick_m1 ? m1_addr  : m0_addr;
                        ram_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    ram_en <= 1'b0;
                    if (state == WAIT)
                        count <= count + 1'b1;
                    if (done) begin
                        state <= RESP;
                        if (grant) begin
                            m1_valid <= 1'b1;
                            m1_rdata <= done_rdata;
                            m1_err   <= timed_out;
                        end else begin
                            m0_valid <= 1'b1;
                            m0_rdata <= done_rdata;
                            m0_err   <= timed_out;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    m0_valid <= 1'b0;
                    m0_err   <= 1'b0;
                    m1_valid <= 1'b0;
                    m1_err   <= 1'b0;
                    count    <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
